// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// The state enum, opcode constants, mux-select encodings and the registered
// control word live here so the top and the wait counter agree on them.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_ALU_WB,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        SRC_A_OLD_PC = 2'd0,
        SRC_A_ZERO   = 2'd1,
        SRC_A_RS1    = 2'd2,
        SRC_A_PC     = 2'd3
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2
    } mem_to_reg_e;

    typedef struct packed {
        logic        ir_write;
        logic        pc_write;
        logic        pc_source;
        logic        reg_write;
        logic        mem_read;
        logic        enable_w;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        mem_to_reg_e mem_to_reg;
        logic        trap;
    } ctrl_t;

    // States that may be held for extra clocks by the wait counter.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_wait_counter.sv
// Wait-state counter for slow ROM/RAM accesses.
// done is registered and means "the current count equals the terminal value";
// done_d is the same comparison on the next count, so the FSM can register
// outputs that must appear in the final wait clock. The terminal value is
// expected to belong to the state being entered or held.
module multicycle_control_wait_counter #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             done,
    output logic             done_d
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             done_q;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
        done_d = (count_d == term);
    end

    // Count and terminal flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, inserting ROM_WAIT and
// RAM_WAIT wait states. Outputs are registered from the next state, except
// the branch PC_WRITE, which follows ZERO combinationally in BRANCH.
// Optional macro MULTICYCLE_PERF_EN adds CYCLE_COUNT and INSTR_COUNT.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned ROM_WAIT = 0,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic        ZERO,
    output logic        IR_WRITE,
    output logic        PC_WRITE,
    output logic        PC_SOURCE,
    output logic        REG_WRITE,
    output logic        MEM_READ,
    output logic        ENABLE_W,
    output logic [1:0]  ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [1:0]  ALU_OP,
    output logic [1:0]  MEM_TO_REG,
    output logic        TRAP
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] CYCLE_COUNT,
    output logic [31:0] INSTR_COUNT
`endif
);

    localparam int unsigned WAIT_MAX = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int unsigned CNT_W    = ($clog2(WAIT_MAX + 1) > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_e           state_q;
    state_e           state_d;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_done;
    logic             cnt_done_d;
    logic [CNT_W-1:0] cnt_term;
    logic             branch_taken;

    // Counter is cleared on entry to a wait state and counts while it is held;
    // the terminal value tracks the state being entered or held.
    always_comb begin
        cnt_clear  = is_wait_state(state_d) && (state_d != state_q);
        cnt_enable = is_wait_state(state_d) && (state_d == state_q);
        cnt_term   = (state_d == S_FETCH) ? CNT_W'(ROM_WAIT) : CNT_W'(RAM_WAIT);
    end

    multicycle_control_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .term   (cnt_term),
        .done   (cnt_done),
        .done_d (cnt_done_d)
    );

    // Next-state logic, including opcode dispatch in DECODE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (cnt_done) state_d = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = (FUNCT3 == 3'b000 || FUNCT3 == 3'b001) ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = (FUNCT3 == 3'b000) ? S_JALR : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_MEM_ADDR: state_d = (OPCODE == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (cnt_done) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (cnt_done) state_d = S_FETCH;
            S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Control word for the state about to be entered; strobes tied to the
    // final wait clock use the counter's next-cycle terminal flag.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.alu_src_a = SRC_A_PC;
                ctrl_d.alu_src_b = SRC_B_FOUR;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.ir_write  = cnt_done_d;
                ctrl_d.pc_write  = cnt_done_d;
            end
            S_DECODE: begin
                ctrl_d.alu_src_a = SRC_A_OLD_PC;
                ctrl_d.alu_src_b = SRC_B_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_RS2;
                ctrl_d.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_IMM;
                ctrl_d.alu_op    = ALU_FUNCT;
            end
            S_EXEC_U: begin
                ctrl_d.alu_src_a = (OPCODE == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
                ctrl_d.alu_src_b = SRC_B_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_ALU_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = WB_ALUOUT;
            end
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEM_RD: ctrl_d.mem_read = 1'b1;
            S_MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: ctrl_d.enable_w = cnt_done_d;
            S_BRANCH: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_RS2;
                ctrl_d.alu_op    = ALU_SUB;
                ctrl_d.pc_source = 1'b1;
            end
            S_JAL: begin
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_source  = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = WB_PC;
            end
            S_JALR: begin
                ctrl_d.alu_src_a  = SRC_A_RS1;
                ctrl_d.alu_src_b  = SRC_B_IMM;
                ctrl_d.alu_op     = ALU_ADD;
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = WB_PC;
            end
            S_TRAP:  ctrl_d.trap = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // State and registered control outputs; reset drops every strobe at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign branch_taken = (FUNCT3 == 3'b001) ? !ZERO : ZERO;

    assign IR_WRITE   = ctrl_q.ir_write;
    assign PC_WRITE   = ctrl_q.pc_write | ((state_q == S_BRANCH) & branch_taken);
    assign PC_SOURCE  = ctrl_q.pc_source;
    assign REG_WRITE  = ctrl_q.reg_write;
    assign MEM_READ   = ctrl_q.mem_read;
    assign ENABLE_W   = ctrl_q.enable_w;
    assign ALU_SRC_A  = ctrl_q.alu_src_a;
    assign ALU_SRC_B  = ctrl_q.alu_src_b;
    assign ALU_OP     = ctrl_q.alu_op;
    assign MEM_TO_REG = ctrl_q.mem_to_reg;
    assign TRAP       = ctrl_q.trap;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count_q;
    logic [31:0] cycle_count_d;
    logic [31:0] instr_count_q;
    logic [31:0] instr_count_d;

    // Active cycles exclude IDLE and TRAP; an instruction completes when
    // FETCH is re-entered from any state other than IDLE.
    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (state_q != S_IDLE && state_q != S_TRAP) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign CYCLE_COUNT = cycle_count_q;
    assign INSTR_COUNT = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances with different wait
// parameters, each checked cycle by cycle against an instruction timeline
// built from the per-class cycle rules.
module tb_multicycle_control;

    localparam int CL_R = 0, CL_I = 1, CL_U = 2, CL_LD = 3, CL_ST = 4;
    localparam int CL_BR = 5, CL_JAL = 6, CL_JALR = 7, CL_TRAP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  [3];
    logic [6:0] opc    [3];
    logic [2:0] f3     [3];
    logic       zero   [3];
    logic       ir_w   [3];
    logic       pc_w   [3];
    logic       pc_s   [3];
    logic       reg_w  [3];
    logic       mem_r  [3];
    logic       en_w   [3];
    logic       tr     [3];
    logic [1:0] src_a  [3];
    logic [1:0] src_b  [3];
    logic [1:0] alu_op [3];
    logic [1:0] m2r    [3];
    logic [14:0] obs   [3];
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc [3];
    logic [31:0] ins [3];
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    multicycle_control #(.ROM_WAIT(0), .RAM_WAIT(1)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n[0]), .OPCODE(opc[0]), .FUNCT3(f3[0]), .ZERO(zero[0]),
        .IR_WRITE(ir_w[0]), .PC_WRITE(pc_w[0]), .PC_SOURCE(pc_s[0]), .REG_WRITE(reg_w[0]),
        .MEM_READ(mem_r[0]), .ENABLE_W(en_w[0]), .ALU_SRC_A(src_a[0]), .ALU_SRC_B(src_b[0]),
        .ALU_OP(alu_op[0]), .MEM_TO_REG(m2r[0]), .TRAP(tr[0])
`ifdef MULTICYCLE_PERF_EN
        , .CYCLE_COUNT(cyc[0]), .INSTR_COUNT(ins[0])
`endif
    );

    multicycle_control #(.ROM_WAIT(0), .RAM_WAIT(2)) u_dut1 (
        .CLK(clk), .RESET_N(rst_n[1]), .OPCODE(opc[1]), .FUNCT3(f3[1]), .ZERO(zero[1]),
        .IR_WRITE(ir_w[1]), .PC_WRITE(pc_w[1]), .PC_SOURCE(pc_s[1]), .REG_WRITE(reg_w[1]),
        .MEM_READ(mem_r[1]), .ENABLE_W(en_w[1]), .ALU_SRC_A(src_a[1]), .ALU_SRC_B(src_b[1]),
        .ALU_OP(alu_op[1]), .MEM_TO_REG(m2r[1]), .TRAP(tr[1])
`ifdef MULTICYCLE_PERF_EN
        , .CYCLE_COUNT(cyc[1]), .INSTR_COUNT(ins[1])
`endif
    );

    multicycle_control #(.ROM_WAIT(2), .RAM_WAIT(3)) u_dut2 (
        .CLK(clk), .RESET_N(rst_n[2]), .OPCODE(opc[2]), .FUNCT3(f3[2]), .ZERO(zero[2]),
        .IR_WRITE(ir_w[2]), .PC_WRITE(pc_w[2]), .PC_SOURCE(pc_s[2]), .REG_WRITE(reg_w[2]),
        .MEM_READ(mem_r[2]), .ENABLE_W(en_w[2]), .ALU_SRC_A(src_a[2]), .ALU_SRC_B(src_b[2]),
        .ALU_OP(alu_op[2]), .MEM_TO_REG(m2r[2]), .TRAP(tr[2])
`ifdef MULTICYCLE_PERF_EN
        , .CYCLE_COUNT(cyc[2]), .INSTR_COUNT(ins[2])
`endif
    );

    // Observed control word per instance: {ir,pcw,pcs,rw,mr,ew,a,b,op,m2r,trap}.
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            obs[d] = {ir_w[d], pc_w[d], pc_s[d], reg_w[d], mem_r[d], en_w[d],
                      src_a[d], src_b[d], alu_op[d], m2r[d], tr[d]};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rom_of(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    function automatic int ram_of(input int d);
        return d + 1;
    endfunction

    function automatic int classify(input logic [6:0] o, input logic [2:0] f);
        case (o)
            7'b0110011: return CL_R;
            7'b0010011: return CL_I;
            7'b0110111, 7'b0010111: return CL_U;
            7'b0000011: return CL_LD;
            7'b0100011: return CL_ST;
            7'b1100011: return (f <= 3'd1) ? CL_BR : CL_TRAP;
            7'b1101111: return CL_JAL;
            7'b1100111: return (f == 3'd0) ? CL_JALR : CL_TRAP;
            default:    return CL_TRAP;
        endcase
    endfunction

    // Bit 15 marks a cycle whose PC_WRITE is the branch decision.
    function automatic logic [15:0] mk(input logic brf, input logic ir, input logic pcw,
                                       input logic pcs, input logic rw, input logic mr,
                                       input logic ew, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] wb, input logic trp);
        return {brf, ir, pcw, pcs, rw, mr, ew, a, b, op, wb, trp};
    endfunction

    // Expected per-cycle timeline of one instruction on instance d.
    task automatic build(input int d, input logic [6:0] o, input logic [2:0] f, input int n_trap);
        int rom = rom_of(d);
        int ram = ram_of(d);
        exp_q.delete();
        for (int k = 0; k <= rom; k++)
            exp_q.push_back(mk(0, k == rom, k == rom, 0, 0, 0, 0, 2'd3, 2'd2, 2'd0, 2'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 0));
        case (classify(o, f))
            CL_R, CL_I, CL_U: begin
                if (classify(o, f) == CL_R)
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0));
                else if (classify(o, f) == CL_I)
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 2'd0, 0));
                else
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, (o == 7'b0110111) ? 2'd1 : 2'd0,
                                       2'd1, 2'd0, 2'd0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
            end
            CL_LD, CL_ST: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 2'd0, 0));
                for (int k = 0; k <= ram; k++) begin
                    if (classify(o, f) == CL_LD)
                        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
                    else
                        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, k == ram, 2'd0, 2'd0, 2'd0, 2'd0, 0));
                end
                if (classify(o, f) == CL_LD)
                    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 0));
            end
            CL_BR:   exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2'd2, 2'd0, 2'd1, 2'd0, 0));
            CL_JAL:  exp_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd2, 0));
            CL_JALR: exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2'd2, 2'd1, 2'd0, 2'd2, 0));
            default: begin
                for (int k = 0; k < n_trap; k++)
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1));
            end
        endcase
    endtask

    // zmode < 0 randomises ZERO each cycle; abort_at >= 0 pulls reset at that cycle.
    task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] f,
                             input int zmode, input int abort_at, input int n_trap);
        logic [15:0] e;
        logic [14:0] ev;
        build(d, o, f, n_trap);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                opc[d] = o;
                f3[d]  = f;
            end
            zero[d] = (zmode < 0) ? 1'($urandom_range(0, 1)) : (zmode != 0);
            #1;
            e  = exp_q[i];
            ev = e[14:0];
            if (e[15]) ev[13] = (f == 3'b001) ? !zero[d] : zero[d];
            check_eq($sformatf("d%0d_op%b_c%0d", d, o, i), 32'(obs[d]), 32'(ev));
            if (i == abort_at) begin
                #1 rst_n[d] = 1'b0;
                #1 check_eq($sformatf("d%0d_abort_drop", d), 32'(obs[d]), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #1 check_eq($sformatf("d%0d_abort_hold%0d", d, k), 32'(obs[d]), 32'd0);
                end
                return;
            end
        end
    endtask

    task automatic start(input int d);
        @(posedge clk);
        #1 rst_n[d] = 1'b1;
        @(negedge clk);
        #1 check_eq($sformatf("d%0d_idle", d), 32'(obs[d]), 32'd0);
    endtask

    task automatic trap_reset(input int d);
        @(negedge clk);
        #2 rst_n[d] = 1'b0;
        #1 check_eq($sformatf("d%0d_trap_clear", d), 32'(obs[d]), 32'd0);
    endtask

    task automatic rand_instr(output logic [6:0] o, output logic [2:0] f);
        int c = $urandom_range(0, 7);
        f = 3'($urandom_range(0, 7));
        case (c)
            0: o = 7'b0110011;
            1: o = 7'b0010011;
            2: o = ($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b0010111;
            3: o = 7'b0000011;
            4: o = 7'b0100011;
            5: begin o = 7'b1100011; f = 3'($urandom_range(0, 1)); end
            6: o = 7'b1101111;
            default: begin o = 7'b1100111; f = 3'd0; end
        endcase
    endtask

    task automatic run_random(input int d, input int n);
        logic [6:0] o;
        logic [2:0] f;
        for (int k = 0; k < n; k++) begin
            rand_instr(o, f);
            run_instr(d, o, f, -1, -1, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            opc[d]   = '0;
            f3[d]    = '0;
            zero[d]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("d%0d_reset", d), 32'(obs[d]), 32'd0);

        // Instance 0 (ROM_WAIT=0, RAM_WAIT=1): R, load, taken bne.
        start(0);
        run_instr(0, 7'b0110011, 3'd0, -1, -1, 0);
        run_instr(0, 7'b0000011, 3'd2, -1, -1, 0);
        run_instr(0, 7'b1100011, 3'd1, 0, -1, 0);
`ifdef MULTICYCLE_PERF_EN
        @(negedge clk);
        #1;
        check_eq("perf_instr", ins[0], 32'd3);
        check_eq("perf_cycle", cyc[0], 32'd13);
        rst_n[0] = 1'b0;
        #1;
        check_eq("perf_instr_rst", ins[0], 32'd0);
        check_eq("perf_cycle_rst", cyc[0], 32'd0);
        start(0);
`endif
        run_random(0, 40);
        run_instr(0, 7'b1100111, 3'd2, -1, -1, 20);
        trap_reset(0);

        // Instance 1 (RAM_WAIT=2): load, not-taken bne, random, illegal opcode.
        start(1);
        run_instr(1, 7'b0000011, 3'd2, -1, -1, 0);
        run_instr(1, 7'b1100011, 3'd1, 1, -1, 0);
        run_random(1, 30);
        run_instr(1, 7'b1111111, 3'd0, -1, -1, 20);
        trap_reset(1);

        // Instance 2 (ROM_WAIT=2, RAM_WAIT=3): store aborted on 2nd MEM_WR clock.
        start(2);
        run_instr(2, 7'b0100011, 3'd2, -1, 6, 0);
        start(2);
        run_random(2, 30);
        run_instr(2, 7'b0001111, 3'd0, -1, -1, 5);
        trap_reset(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multi-cycle variant of the RV32I core datapath. Fetch, decode, execute, memory and writeback each take one or more clocks.
- Drives the register, ALU-operand, PC and memory enables that the single-cycle control path derives combinationally.
- Inserts parameterised wait states for slow ROM/RAM.
- Sits beside the datapath. Consumes IR fields and the ALU ZERO flag.

Parameters:
- ROM_WAIT, 0, extra clocks an instruction fetch is held before IR capture.
- RAM_WAIT, 1, extra clocks a load/store access is held.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous active-low reset.
- OPCODE  in  7  IR[6:0], valid from DECODE onward.
- FUNCT3  in  3  IR[14:12].
- ZERO  in  1  main ALU zero flag.
- IR_WRITE  out  1  capture Q_ROM into IR and PC into OLD_PC.
- PC_WRITE  out  1  load PC from the PC_SOURCE mux.
- PC_SOURCE  out  1  0 = ALU result, 1 = ALUOut register.
- REG_WRITE  out  1  register file write.
- MEM_READ  out  1  RAM read strobe.
- ENABLE_W  out  1  RAM write strobe.
- ALU_SRC_A  out  2  0 = OLD_PC, 1 = zero, 2 = rs1, 3 = PC.
- ALU_SRC_B  out  2  0 = rs2, 1 = imm, 2 = constant 4.
- ALU_OP  out  2  0 = ADD, 1 = SUB, 2 = funct decode by ALU_CONTROL.
- MEM_TO_REG  out  2  0 = ALUOut, 1 = MDR, 2 = PC (already PC+4).
- TRAP  out  1  illegal instruction; sticky until reset.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, ALU_WB, TRAP.
- Reset (asynchronous): state = IDLE, wait counter = 0.
  - In IDLE every output is 0. All selects are 0 and TRAP = 0.
  - IDLE always goes to FETCH on the next clock.
- Wait counter:
  - Width = max(1, clog2(max(ROM_WAIT, RAM_WAIT) + 1)).
  - Cleared on entering any wait-capable state; increments each clock while in it.
- FETCH:
  - Drives A = 3, B = 2, OP = 0.
  - Held ROM_WAIT + 1 clocks.
  - IR_WRITE and PC_WRITE (PC_SOURCE = 0) pulse only in the final cycle, when the counter equals ROM_WAIT. Next state is DECODE.
- DECODE:
  - Drives A = 0, B = 1, OP = 0, so ALUOut = OLD_PC + imm.
  - Dispatch on OPCODE:
    - 0110011 goes to EXEC_R.
    - 0010011 goes to EXEC_I.
    - 0110111 (LUI) and 0010111 (AUIPC) go to EXEC_U.
    - 0000011 and 0100011 go to MEM_ADDR.
    - 1100011 goes to BRANCH, but only if FUNCT3 is 000 or 001.
    - 1101111 goes to JAL.
    - 1100111 goes to JALR, but only if FUNCT3 = 000.
    - Anything else goes to TRAP.
- EXEC_R: A = 2, B = 0, OP = 2, then ALU_WB.
- EXEC_I: A = 2, B = 1, OP = 2, then ALU_WB.
- EXEC_U: B = 1, OP = 0, then ALU_WB.
  - A = 1 for LUI.
  - A = 0 for AUIPC.
- ALU_WB: REG_WRITE = 1, MEM_TO_REG = 0, then FETCH.
- MEM_ADDR: A = 2, B = 1, OP = 0, then MEM_RD if OPCODE = 0000011, else MEM_WR.
- MEM_RD:
  - MEM_READ = 1 for RAM_WAIT + 1 clocks; MDR captures in the last of them.
  - Then MEM_WB: REG_WRITE = 1, MEM_TO_REG = 1, then FETCH.
- MEM_WR:
  - ENABLE_W is a single-cycle pulse in the final clock of RAM_WAIT + 1. It is 0 in all earlier wait clocks.
  - Then FETCH.
- BRANCH:
  - Drives A = 2, B = 0, OP = 1, PC_SOURCE = 1.
  - Taken = (FUNCT3 == 001) ? !ZERO : ZERO.
  - PC_WRITE = taken, combinational from ZERO within the same cycle.
  - Then FETCH.
- JAL: PC_WRITE = 1, PC_SOURCE = 1, REG_WRITE = 1, MEM_TO_REG = 2, then FETCH.
- JALR: A = 2, B = 1, OP = 0, PC_WRITE = 1, PC_SOURCE = 0, REG_WRITE = 1, MEM_TO_REG = 2, then FETCH.
- TRAP: all strobes 0, TRAP = 1. The state is absorbing; only RESET_N leaves it.
- Cycle counts with ROM_WAIT = 0:
  - R-type, I-type and U-type: 4.
  - Load: 5 + RAM_WAIT.
  - Store: 4 + RAM_WAIT.
  - Branch, JAL and JALR: 3.
- Reset asserted mid-access (any state, any counter value): state goes to IDLE and all strobes drop in the same instant. No partial ENABLE_W may follow.
- A strobe (IR_WRITE, PC_WRITE, REG_WRITE, ENABLE_W) never lasts more than one clock per instruction. MEM_READ is the only level-type signal.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- When defined, adds two 32-bit outputs:
  - CYCLE_COUNT: increments every clock outside IDLE and TRAP.
  - INSTR_COUNT: increments on each transition into FETCH from a completing state, i.e. not from IDLE.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor register exists.

Decomposition:
- Shared package multicycle_pkg holds:
  - the state enum;
  - opcode localparams (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - encodings for ALU_SRC_A/B, ALU_OP and MEM_TO_REG.
- One sub-module: wait_counter, which provides clear, enable and a done flag at a programmable terminal value.

Test Plan:
- Reset release, then OPCODE = 0110011 -> IDLE 1 clk; IR_WRITE+PC_WRITE at clk 2; REG_WRITE at clk 5; next IR_WRITE at clk 6.
- RAM_WAIT = 2, load 0000011 -> MEM_READ high exactly 3 clks; REG_WRITE with MEM_TO_REG = 1 one clk later; 7 clks total.
- Branch FUNCT3 = 001 with ZERO = 0 -> PC_WRITE = 1 and PC_SOURCE = 1 in BRANCH. Same with ZERO = 1 -> PC_WRITE = 0, returns to FETCH.
- OPCODE = 1111111 and separately JALR with FUNCT3 = 010 -> TRAP = 1 from next clk, all strobes 0 for 20 clks, cleared by RESET_N.
- Store with RAM_WAIT = 3, RESET_N pulled low on the 2nd MEM_WR clock -> ENABLE_W never asserted; IDLE then FETCH after release.
- MULTICYCLE_PERF_EN: run R, load (RAM_WAIT = 1), branch -> INSTR_COUNT = 3; CYCLE_COUNT = 4 + 6 + 3 = 13.
